// File: rtl/sd_bd_pkg.sv
// Shared constants and types for the SD buffer-descriptor ring.
package sd_bd_pkg;

  localparam int unsigned BD_WORDS = 2;
  localparam logic BD_W_MEMADR = 1'b0;
  localparam logic BD_W_CARDADR = 1'b1;
  localparam int unsigned FREE_W = 8;

  typedef enum logic [1:0] {
    BD_IDLE,
    BD_W0,
    BD_W1
  } bd_rd_state_e;

endpackage

// File: rtl/sd_bd_mem.sv
// Simple dual-port descriptor RAM: one write port, one registered read port.
module sd_bd_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is reset so the output starts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_bd_ring.sv
// Circular buffer-descriptor store: two-word descriptors written by the register
// block, issued to the transfer engine on request, retired on transfer done.
module sd_bd_ring
  import sd_bd_pkg::*;
#(
  parameter int unsigned BD_DEPTH = 8,
  parameter int unsigned DW = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              clr_i,
  input  logic              we_m_i,
  input  logic [DW-1:0]     dat_in_m_i,
  input  logic              re_s_i,
  output logic [DW-1:0]     dat_out_s_o,
  output logic              ack_s_o,
  input  logic              done_s_i,
  output logic [FREE_W-1:0] free_bd_o,
  output logic              bd_pending_o,
  output logic              ovf_o
);

  localparam int unsigned PW = $clog2(BD_DEPTH);
  localparam int unsigned AW = PW + 1;
  localparam logic [FREE_W-1:0] DEPTH_CNT = FREE_W'(BD_DEPTH);

  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, rt_ptr_q;
  logic [FREE_W-1:0] free_q, free_d, pend_q, pend_d, issued;
  logic              half_q, ack_q, ovf_q, pflag_q;
  bd_rd_state_e      state_q;

  logic commit, drop, wr_en, retire, rd_start, rd_last, ram_re;
  logic [AW-1:0] waddr, raddr;

  always_comb begin
    commit   = we_m_i & half_q;
    drop     = we_m_i & ~half_q & (free_q == '0);
    wr_en    = we_m_i & ~drop & ~clr_i;
    // Slots in use are either still pending (incl. mid-read) or issued and awaiting done.
    issued   = DEPTH_CNT - free_q - pend_q;
    retire   = done_s_i & (issued != '0);
    rd_start = (state_q == BD_IDLE) & re_s_i & (pend_q != '0);
    rd_last  = (state_q == BD_W1);
    ram_re   = ~clr_i & (rd_start | (state_q == BD_W0));
    waddr    = {wr_ptr_q, half_q ? BD_W_CARDADR : BD_W_MEMADR};
    raddr    = {rd_ptr_q, (state_q == BD_W0) ? BD_W_CARDADR : BD_W_MEMADR};

    free_d = free_q;
    if (commit && !retire) free_d = free_q - 1'b1;
    else if (retire && !commit) free_d = free_q + 1'b1;
    pend_d = pend_q + FREE_W'(commit) - FREE_W'(rd_last);
  end

  sd_bd_mem #(
    .DEPTH(BD_DEPTH * BD_WORDS),
    .DW   (DW),
    .AW   (AW)
  ) u_mem (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .we   (wr_en),
    .waddr(waddr),
    .wdata(dat_in_m_i),
    .re   (ram_re),
    .raddr(raddr),
    .rdata(dat_out_s_o)
  );

  // Read FSM with registered ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= BD_IDLE;
      ack_q    <= 1'b0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      state_q  <= BD_IDLE;
      ack_q    <= 1'b0;
      rd_ptr_q <= '0;
    end else begin
      case (state_q)
        BD_IDLE: begin
          if (rd_start) begin
            state_q <= BD_W0;
            ack_q   <= 1'b1;
          end
        end
        BD_W0: state_q <= BD_W1;
        BD_W1: begin
          state_q  <= BD_IDLE;
          ack_q    <= 1'b0;
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        default: begin
          state_q <= BD_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rt_ptr_q <= '0;
      free_q   <= DEPTH_CNT;
      pend_q   <= '0;
      pflag_q  <= 1'b0;
      half_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rt_ptr_q <= '0;
      free_q   <= DEPTH_CNT;
      pend_q   <= '0;
      pflag_q  <= 1'b0;
      half_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      free_q  <= free_d;
      pend_q  <= pend_d;
      pflag_q <= (pend_d != '0);
      ovf_q   <= drop;
      if (wr_en) half_q <= ~half_q;
      if (commit) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (retire) rt_ptr_q <= rt_ptr_q + PW'(1);
    end
  end

  assign ack_s_o      = ack_q;
  assign free_bd_o    = free_q;
  assign bd_pending_o = pflag_q;
  assign ovf_o        = ovf_q;

endmodule
